a5_frame_ctrl: RTL and testbench
================================

Name: a5_frame_ctrl

Overview:
Sequencer for the A5/1 keystream core. Per frame it:
- loads the 64-bit session key and 22-bit frame number into the core;
- waits for the core's internal 64+22+100-step initialisation;
- gates 2*BURST_LEN keystream steps and packs them into two bursts (A: downlink, B: uplink);
- presents the bursts to the downstream encryptor over a valid/ready handshake.

Optionally auto-increments the frame number and restarts for the next frame.

Parameters:
- BURST_LEN, 114, keystream bits per burst; legal range 1..255.
- FN_W, 22, frame-number width; must equal the core's frame-number input width.
- TMO_CYC, 1024, cycles allowed in WAIT_INIT before error (used only with A5_INIT_TMO_EN).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse in IDLE: latch key_in/fn_in and begin a frame.
- auto_next  in  1  sampled at burst handshake: 1 = increment fn and run the next frame automatically.
- key_in  in  64  session key.
- fn_in  in  FN_W  initial frame number.
- core_load  out  1  one-cycle pulse: core restarts initialisation from core_key/core_fn.
- core_key  out  64  latched key driven to the core.
- core_fn  out  FN_W  current frame number driven to the core.
- core_busy  in  1  core initialisation in progress (core init flag).
- core_ks_en  out  1  request one keystream step this cycle.
- core_ks_bit  in  1  keystream bit, valid the cycle after core_ks_en.
- burst_valid  out  1  bursts A/B available.
- burst_ready  in  1  downstream accepts.
- burst_a  out  BURST_LEN  first BURST_LEN bits; first bit in MSB.
- burst_b  out  BURST_LEN  next BURST_LEN bits; first bit in MSB.
- burst_fn  out  FN_W  frame number of the presented bursts.
- busy  out  1  state != IDLE.
- err  out  1  sticky timeout error (A5_INIT_TMO_EN only, else tied 0).

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counters 0.
- States:
  - IDLE: start=1 latches key_in/fn_in → LOAD. start is ignored in every other state.
  - LOAD: core_load=1 for exactly one cycle → WAIT_INIT.
  - WAIT_INIT: the first cycle is a blanking cycle and core_busy is ignored. From the second cycle on, core_busy=0 → GEN.
  - GEN: core_ks_en=1 while issued count < 2*BURST_LEN. Each cycle after an issued step, core_ks_bit shifts in. Bits 0..BURST_LEN-1 go to burst_a and the rest to burst_b, MSB-first. When captured count = 2*BURST_LEN → OUT. GEN lasts exactly 2*BURST_LEN+1 cycles; core_ks_en is high for the first 2*BURST_LEN of them.
  - OUT: burst_valid=1. burst_a, burst_b and burst_fn stay stable until the handshake (burst_valid & burst_ready). On handshake:
    - auto_next=1: core_fn ← core_fn+1, wrapping from 2^FN_W-1 to 0 → LOAD.
    - auto_next=0 → IDLE.
- burst_valid drops the cycle after the handshake. burst_a/b/fn hold their last values until the next OUT.
- Latency, start to burst_valid: 1 (LOAD) + 1 (blank) + N_init (core_busy high) + 2*BURST_LEN+1 + 1 cycles.
- Core interface: core_key and core_fn are stable whenever core_load is high and throughout WAIT_INIT/GEN.
- rst_n asserted mid-frame: immediate return to IDLE; burst_valid=0, core_load=0, core_ks_en=0; partial bursts are discarded.
- burst_ready held high before OUT has no effect.

Optional Feature:
- A5_INIT_TMO_EN defined:
  - A cycle counter runs in WAIT_INIT.
  - If core_busy is still 1 after TMO_CYC cycles: err ← 1 (sticky until rst_n) and state → IDLE with no burst output.
  - start is accepted again after the timeout; err stays 1.
- Not defined: no counter is instantiated, err is constant 0, and WAIT_INIT waits indefinitely.

Test Plan:
- Known vector:
  - Stimulus: key 0x1223456789ABCDEF, fn 0x134, core model held busy 186 cycles, auto_next=0, burst_ready=1.
  - Required: one core_load pulse; exactly 228 core_ks_en cycles; burst_a/burst_b equal the golden model's first/second 114 bits; busy falls; state IDLE.
- Backpressure:
  - Stimulus: burst_ready=0 for 50 cycles in OUT.
  - Required: burst_valid held; burst_a/b/fn unchanged across all 50 cycles; handshake on the first ready=1 cycle; valid=0 the next cycle.
- Auto-next wrap:
  - Stimulus: fn_in=0x3FFFFF, auto_next=1 for 2 frames.
  - Required: burst_fn 0x3FFFFF, then 0x000000; second core_load the cycle after the first handshake.
- Reset mid-GEN:
  - Stimulus: rst_n low after 60 ks steps, released, then new start.
  - Required: outputs 0 during reset; the next frame yields a full 228-bit, correct result.
- start ignored:
  - Stimulus: start pulses during WAIT_INIT and OUT.
  - Required: no extra core_load; latched key and fn unchanged.
- Timeout (A5_INIT_TMO_EN):
  - Stimulus: TMO_CYC=16, core_busy stuck at 1.
  - Required: err=1 after 16 WAIT_INIT cycles, state IDLE, no burst_valid. A new start succeeds with err still 1.

Source files
------------

// File: rtl/a5_frame_ctrl.sv
// Frame sequencer for the A5/1 keystream core: key/fn load, init wait, 2*BURST_LEN keystream capture, burst hand-off.
// Optional init watchdog enabled by defining A5_INIT_TMO_EN.
module a5_frame_ctrl #(
  parameter int BURST_LEN = 114,
  parameter int FN_W      = 22,
  parameter int TMO_CYC   = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 auto_next,
  input  logic [63:0]          key_in,
  input  logic [FN_W-1:0]      fn_in,
  output logic                 core_load,
  output logic [63:0]          core_key,
  output logic [FN_W-1:0]      core_fn,
  input  logic                 core_busy,
  output logic                 core_ks_en,
  input  logic                 core_ks_bit,
  output logic                 burst_valid,
  input  logic                 burst_ready,
  output logic [BURST_LEN-1:0] burst_a,
  output logic [BURST_LEN-1:0] burst_b,
  output logic [FN_W-1:0]      burst_fn,
  output logic                 busy,
  output logic                 err,
  output logic [2:0]           state_dbg
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_GEN  = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  localparam int         TOTAL   = 2 * BURST_LEN;
  localparam logic [8:0] TOTAL_C = 9'(TOTAL);

  logic [2:0]       state;
  logic [2:0]       state_nx;
  logic             blank;
  logic [8:0]       iss_cnt;
  logic [8:0]       cap_cnt;
  logic             cap_pend;
  logic [TOTAL-1:0] sr;
  logic [TOTAL-1:0] sr_nx;
  logic             last_cap;
  logic             handshake;
  logic             tmo_hit;

  // Handshake: a burst transfers on a cycle with burst_valid & burst_ready; while
  // burst_valid is high and ready is low, burst_a/burst_b/burst_fn do not change.
  assign core_load   = (state == S_LOAD);
  assign core_ks_en  = (state == S_GEN) && (iss_cnt < TOTAL_C);
  assign burst_valid = (state == S_OUT);
  assign busy        = (state != S_IDLE);
  assign state_dbg   = state;
  assign handshake   = burst_valid & burst_ready;

  // The core answers one cycle after each enable, so capture trails issue by one cycle.
  assign sr_nx    = {sr[TOTAL-2:0], core_ks_bit};
  assign last_cap = cap_pend && (cap_cnt == TOTAL_C - 9'd1);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_LOAD;
      S_LOAD: state_nx = S_WAIT;
      S_WAIT: begin
        if (tmo_hit) state_nx = S_IDLE;
        else if (!blank && !core_busy) state_nx = S_GEN;
      end
      S_GEN:  if (last_cap) state_nx = S_OUT;
      S_OUT:  if (handshake) state_nx = auto_next ? S_LOAD : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      core_key <= '0;
      core_fn  <= '0;
      blank    <= 1'b0;
      iss_cnt  <= '0;
      cap_cnt  <= '0;
      cap_pend <= 1'b0;
      sr       <= '0;
      burst_a  <= '0;
      burst_b  <= '0;
      burst_fn <= '0;
    end else begin
      state    <= state_nx;
      cap_pend <= core_ks_en;
      // The core samples its busy flag from the load, so the first WAIT cycle is blind.
      blank    <= (state == S_LOAD);
      if (state == S_IDLE && start) begin
        core_key <= key_in;
        core_fn  <= fn_in;
      end
      if (handshake && auto_next) core_fn <= core_fn + 1'b1;
      if (state == S_LOAD) begin
        iss_cnt <= '0;
        cap_cnt <= '0;
      end
      if (core_ks_en) iss_cnt <= iss_cnt + 9'd1;
      if (cap_pend) begin
        sr      <= sr_nx;
        cap_cnt <= cap_cnt + 9'd1;
      end
      if (last_cap) begin
        burst_a  <= sr_nx[TOTAL-1:BURST_LEN];
        burst_b  <= sr_nx[BURST_LEN-1:0];
        burst_fn <= core_fn;
      end
    end
  end

`ifdef A5_INIT_TMO_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  assign tmo_hit = (state == S_WAIT) && core_busy && (tmo_cnt == TMO_W'(TMO_CYC - 1));
  assign err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == S_WAIT) tmo_cnt <= tmo_cnt + 1'b1;
      else tmo_cnt <= '0;
      if (tmo_hit) err_q <= 1'b1;
    end
  end
`else
  logic unused_tmo;

  assign tmo_hit    = 1'b0;
  assign err        = 1'b0;
  assign unused_tmo = ^TMO_CYC;
`endif

endmodule

// File: tb/tb_a5_frame_ctrl.sv
// Self-checking bench for a5_frame_ctrl: behavioural A5/1 core model plus a keystream reference model.
`timescale 1ns/1ps
module tb_a5_frame_ctrl;
  localparam int BL   = 114;
  localparam int FN_W = 22;
  localparam int KS_N = 2 * BL;
  localparam int TMO  = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            auto_next = 1'b0;
  logic [63:0]     key_in = '0;
  logic [FN_W-1:0] fn_in = '0;
  logic            core_load;
  logic [63:0]     core_key;
  logic [FN_W-1:0] core_fn;
  logic            core_busy;
  logic            core_ks_en;
  logic            core_ks_bit;
  logic            burst_valid;
  logic            burst_ready = 1'b0;
  logic [BL-1:0]   burst_a;
  logic [BL-1:0]   burst_b;
  logic [FN_W-1:0] burst_fn;
  logic            busy;
  logic            err;
  logic [2:0]      state_dbg;

  int   n_tests = 0;
  int   n_fail = 0;
  int   init_cycles = 186;
  logic busy_stuck = 1'b0;
  int   load_cnt = 0;
  int   ks_en_cnt = 0;
  int   valid_cnt = 0;

  always #5 clk = ~clk;

  a5_frame_ctrl #(.BURST_LEN(BL), .FN_W(FN_W), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .auto_next(auto_next),
    .key_in(key_in), .fn_in(fn_in), .core_load(core_load), .core_key(core_key),
    .core_fn(core_fn), .core_busy(core_busy), .core_ks_en(core_ks_en),
    .core_ks_bit(core_ks_bit), .burst_valid(burst_valid), .burst_ready(burst_ready),
    .burst_a(burst_a), .burst_b(burst_b), .burst_fn(burst_fn), .busy(busy),
    .err(err), .state_dbg(state_dbg)
  );

  // Reference A5/1: key then frame number mixed in, 100 silent steps, then KS_N output bits.
  function automatic logic [KS_N-1:0] a5_ks(input logic [63:0] k, input logic [FN_W-1:0] f);
    logic [18:0] r1;
    logic [21:0] r2;
    logic [22:0] r3;
    logic [KS_N-1:0] ks;
    logic maj;
    r1 = '0; r2 = '0; r3 = '0; ks = '0;
    for (int i = 0; i < 64 + FN_W; i++) begin
      logic b;
      b  = (i < 64) ? k[i] : f[i-64];
      r1 = {r1[17:0], r1[13] ^ r1[16] ^ r1[17] ^ r1[18] ^ b};
      r2 = {r2[20:0], r2[20] ^ r2[21] ^ b};
      r3 = {r3[21:0], r3[7] ^ r3[20] ^ r3[21] ^ r3[22] ^ b};
    end
    for (int i = 0; i < 100 + KS_N; i++) begin
      maj = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
      if (r1[8] == maj)  r1 = {r1[17:0], r1[13] ^ r1[16] ^ r1[17] ^ r1[18]};
      if (r2[10] == maj) r2 = {r2[20:0], r2[20] ^ r2[21]};
      if (r3[10] == maj) r3 = {r3[21:0], r3[7] ^ r3[20] ^ r3[21] ^ r3[22]};
      if (i >= 100) ks[i-100] = r1[18] ^ r2[21] ^ r3[22];
    end
    return ks;
  endfunction

  function automatic logic [BL-1:0] exp_burst(input logic [63:0] k, input logic [FN_W-1:0] f,
                                              input int half);
    logic [KS_N-1:0] ks;
    logic [BL-1:0] r;
    ks = a5_ks(k, f);
    for (int j = 0; j < BL; j++) r[BL-1-j] = ks[half*BL + j];
    return r;
  endfunction

  // Core model: busy for init_cycles after a load, one keystream bit the cycle after each enable.
  logic [KS_N-1:0] core_ks;
  int ks_ptr;
  int busy_left;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_busy <= 1'b0; busy_left <= 0; ks_ptr <= 0; core_ks_bit <= 1'b0; core_ks <= '0;
    end else begin
      if (core_load) begin
        core_ks   <= a5_ks(core_key, core_fn);
        ks_ptr    <= 0;
        busy_left <= init_cycles;
        core_busy <= (init_cycles != 0) || busy_stuck;
      end else begin
        if (busy_left > 0) busy_left <= busy_left - 1;
        core_busy <= busy_stuck || (busy_left > 1);
      end
      if (core_ks_en) begin
        core_ks_bit <= (ks_ptr < KS_N) ? core_ks[ks_ptr] : 1'b0;
        ks_ptr <= ks_ptr + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (core_load) load_cnt++;
    if (core_ks_en) ks_en_cnt++;
    if (burst_valid) valid_cnt++;
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic pulse_start(input logic [63:0] k, input logic [FN_W-1:0] f);
    key_in = k; fn_in = f; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (burst_valid) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL wait_valid: burst_valid=0 after %0d cycles, required 1", budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({burst_valid, core_load, core_ks_en, busy, err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 00000", {burst_valid, core_load, core_ks_en, busy, err});
    end
    n_tests++;
    if (burst_a !== '0 || burst_b !== '0 || burst_fn !== '0 || core_key !== '0 || core_fn !== '0) begin
      n_fail++; $display("FAIL reset_data: a=%h b=%h fn=%h key=%h cfn=%h required all 0", burst_a, burst_b, burst_fn, core_key, core_fn);
    end
    n_tests++;
    if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d required 0", state_dbg); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_known_vector();
    logic [63:0] k;
    logic [FN_W-1:0] f;
    bit ok;
    int l0, e0;
    k = 64'h1223456789ABCDEF; f = 22'h134;
    init_cycles = 186; auto_next = 1'b0; burst_ready = 1'b1;
    l0 = load_cnt; e0 = ks_en_cnt;
    pulse_start(k, f);
    wait_valid(1000, ok);
    if (ok) begin
      n_tests++;
      if (burst_a !== exp_burst(k, f, 0)) begin n_fail++; $display("FAIL kv_burst_a: got %h required %h", burst_a, exp_burst(k, f, 0)); end
      n_tests++;
      if (burst_b !== exp_burst(k, f, 1)) begin n_fail++; $display("FAIL kv_burst_b: got %h required %h", burst_b, exp_burst(k, f, 1)); end
      n_tests++;
      if (burst_fn !== f || core_key !== k) begin n_fail++; $display("FAIL kv_fn_key: fn=%h key=%h required %h %h", burst_fn, core_key, f, k); end
      tick();
      n_tests++;
      if ({burst_valid, busy} !== 2'b00 || state_dbg !== 3'd0) begin
        n_fail++; $display("FAIL kv_done: valid=%b busy=%b state=%0d required 0 0 0", burst_valid, busy, state_dbg);
      end
      n_tests++;
      if (load_cnt - l0 != 1) begin n_fail++; $display("FAIL kv_load_count: got %0d required 1", load_cnt - l0); end
      n_tests++;
      if (ks_en_cnt - e0 != KS_N) begin n_fail++; $display("FAIL kv_ks_en_count: got %0d required %0d", ks_en_cnt - e0, KS_N); end
      n_tests++;
      if (burst_a !== exp_burst(k, f, 0)) begin n_fail++; $display("FAIL kv_hold_after: got %h required %h", burst_a, exp_burst(k, f, 0)); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] k;
    logic [FN_W-1:0] f;
    logic [BL-1:0] ea, eb;
    bit ok;
    int bad;
    k = {$urandom, $urandom}; f = FN_W'($urandom);
    ea = exp_burst(k, f, 0); eb = exp_burst(k, f, 1);
    init_cycles = $urandom_range(2, 40); auto_next = 1'b0; burst_ready = 1'b0;
    pulse_start(k, f);
    wait_valid(800, ok);
    if (ok) begin
      bad = 0;
      for (int i = 0; i < 50; i++) begin
        if (burst_valid !== 1'b1 || burst_a !== ea || burst_b !== eb || burst_fn !== f) bad++;
        tick();
      end
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL bp_hold: %0d unstable cycles, required 0", bad); end
      burst_ready = 1'b1;
      tick();
      burst_ready = 1'b0;
      n_tests++;
      if (burst_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drop: valid=%b required 0", burst_valid); end
      n_tests++;
      if (burst_a !== ea || burst_b !== eb || burst_fn !== f) begin
        n_fail++; $display("FAIL bp_data_hold: a=%h fn=%h required %h %h", burst_a, burst_fn, ea, f);
      end
    end
  endtask

  task automatic test_auto_next_wrap();
    logic [63:0] k;
    bit ok;
    k = {$urandom, $urandom};
    init_cycles = 20; auto_next = 1'b1; burst_ready = 1'b1;
    pulse_start(k, 22'h3FFFFF);
    wait_valid(800, ok);
    if (ok) begin
      n_tests++;
      if (burst_fn !== 22'h3FFFFF || burst_a !== exp_burst(k, 22'h3FFFFF, 0) || burst_b !== exp_burst(k, 22'h3FFFFF, 1)) begin
        n_fail++; $display("FAIL wrap_first: fn=%h a=%h required fn 3fffff a=%h", burst_fn, burst_a, exp_burst(k, 22'h3FFFFF, 0));
      end
      tick();
      auto_next = 1'b0;
      n_tests++;
      if ({core_load, burst_valid} !== 2'b10 || core_fn !== '0) begin
        n_fail++; $display("FAIL wrap_reload: load=%b valid=%b core_fn=%h required 1 0 0", core_load, burst_valid, core_fn);
      end
      wait_valid(800, ok);
      if (ok) begin
        n_tests++;
        if (burst_fn !== '0 || burst_a !== exp_burst(k, '0, 0) || burst_b !== exp_burst(k, '0, 1)) begin
          n_fail++; $display("FAIL wrap_second: fn=%h b=%h required fn 0 b=%h", burst_fn, burst_b, exp_burst(k, '0, 1));
        end
        tick();
        n_tests++;
        if ({burst_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL wrap_end: valid=%b busy=%b required 0 0", burst_valid, busy); end
      end
    end
  endtask

  task automatic test_reset_mid_gen();
    logic [63:0] k;
    logic [FN_W-1:0] f;
    bit ok;
    int e0, c;
    k = {$urandom, $urandom}; f = FN_W'($urandom);
    init_cycles = 10; auto_next = 1'b0; burst_ready = 1'b1;
    e0 = ks_en_cnt;
    pulse_start(k, f);
    c = 0;
    while (ks_en_cnt - e0 < 60 && c < 500) begin tick(); c++; end
    n_tests++;
    if (ks_en_cnt - e0 != 60) begin n_fail++; $display("FAIL rst_reach_gen: steps=%0d required 60", ks_en_cnt - e0); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({burst_valid, core_load, core_ks_en, busy} !== 4'b0 || state_dbg !== 3'd0) begin
      n_fail++; $display("FAIL rst_mid_ctrl: v/l/en/busy=%b state=%0d required 0000 0", {burst_valid, core_load, core_ks_en, busy}, state_dbg);
    end
    n_tests++;
    if (burst_a !== '0 || core_fn !== '0 || core_key !== '0) begin
      n_fail++; $display("FAIL rst_mid_data: a=%h fn=%h key=%h required 0", burst_a, core_fn, core_key);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    k = {$urandom, $urandom}; f = FN_W'($urandom);
    e0 = ks_en_cnt;
    pulse_start(k, f);
    wait_valid(800, ok);
    if (ok) begin
      n_tests++;
      if (burst_a !== exp_burst(k, f, 0) || burst_b !== exp_burst(k, f, 1) || burst_fn !== f) begin
        n_fail++; $display("FAIL rst_next_frame: a=%h b=%h required %h %h", burst_a, burst_b, exp_burst(k, f, 0), exp_burst(k, f, 1));
      end
      n_tests++;
      if (ks_en_cnt - e0 != KS_N) begin n_fail++; $display("FAIL rst_next_steps: got %0d required %0d", ks_en_cnt - e0, KS_N); end
      tick();
    end
  endtask

  task automatic test_start_ignored();
    logic [63:0] k1, k2;
    logic [FN_W-1:0] f1, f2;
    bit ok;
    int l0;
    k1 = {$urandom, $urandom}; f1 = FN_W'($urandom);
    k2 = ~k1; f2 = ~f1;
    init_cycles = 30; auto_next = 1'b0; burst_ready = 1'b0;
    l0 = load_cnt;
    pulse_start(k1, f1);
    tick();
    pulse_start(k2, f2);
    tick();
    pulse_start(k2, f2);
    wait_valid(800, ok);
    if (ok) begin
      pulse_start(k2, f2);
      pulse_start(k2, f2);
      n_tests++;
      if (core_key !== k1 || core_fn !== f1 || burst_fn !== f1) begin
        n_fail++; $display("FAIL si_latched: key=%h fn=%h bfn=%h required %h %h", core_key, core_fn, burst_fn, k1, f1);
      end
      n_tests++;
      if (burst_valid !== 1'b1 || burst_a !== exp_burst(k1, f1, 0) || burst_b !== exp_burst(k1, f1, 1)) begin
        n_fail++; $display("FAIL si_bursts: valid=%b a=%h required 1 %h", burst_valid, burst_a, exp_burst(k1, f1, 0));
      end
      burst_ready = 1'b1;
      tick();
      burst_ready = 1'b0;
      tick(); tick();
      n_tests++;
      if (load_cnt - l0 != 1 || busy !== 1'b0) begin
        n_fail++; $display("FAIL si_loads: loads=%0d busy=%b required 1 0", load_cnt - l0, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] k;
    logic [FN_W-1:0] f;
    bit done;
    for (int fr = 0; fr < 4; fr++) begin
      k = {$urandom, $urandom}; f = FN_W'($urandom);
      init_cycles = $urandom_range(0, 20); auto_next = 1'b0;
      pulse_start(k, f);
      done = 1'b0;
      for (int c = 0; c < 900 && !done; c++) begin
        burst_ready = 1'($urandom_range(0, 1));
        if (burst_valid && burst_ready) begin
          done = 1'b1;
          n_tests++;
          if (burst_a !== exp_burst(k, f, 0) || burst_b !== exp_burst(k, f, 1) || burst_fn !== f) begin
            n_fail++; $display("FAIL b2b_frame%0d: a=%h fn=%h required %h %h", fr, burst_a, burst_fn, exp_burst(k, f, 0), f);
          end
        end
        tick();
      end
      burst_ready = 1'b0;
      n_tests++;
      if (!done || burst_valid !== 1'b0) begin
        n_fail++; $display("FAIL b2b_handshake%0d: done=%b valid=%b required 1 0", fr, done, burst_valid);
      end
    end
  endtask

`ifdef A5_INIT_TMO_EN
  task automatic test_timeout();
    logic [63:0] k;
    logic [FN_W-1:0] f;
    bit ok;
    int v0, e0, cyc;
    k = {$urandom, $urandom}; f = FN_W'($urandom);
    busy_stuck = 1'b1; burst_ready = 1'b1; auto_next = 1'b0;
    v0 = valid_cnt; e0 = ks_en_cnt;
    pulse_start(k, f);
    cyc = 0;
    while (busy && cyc < 200) begin tick(); cyc++; end
    n_tests++;
    if (cyc != TMO + 1) begin n_fail++; $display("FAIL tmo_cycles: busy for %0d cycles after load, required %0d", cyc, TMO + 1); end
    n_tests++;
    if (err !== 1'b1 || state_dbg !== 3'd0 || valid_cnt != v0 || ks_en_cnt != e0) begin
      n_fail++; $display("FAIL tmo_state: err=%b state=%0d valids=%0d steps=%0d required 1 0 0 0", err, state_dbg, valid_cnt - v0, ks_en_cnt - e0);
    end
    busy_stuck = 1'b0; init_cycles = 5;
    pulse_start(k, f);
    wait_valid(800, ok);
    if (ok) begin
      n_tests++;
      if (burst_a !== exp_burst(k, f, 0) || burst_b !== exp_burst(k, f, 1) || err !== 1'b1) begin
        n_fail++; $display("FAIL tmo_recover: a=%h err=%b required %h 1", burst_a, err, exp_burst(k, f, 0));
      end
      tick();
    end
  endtask
`else
  task automatic test_no_timeout();
    logic [63:0] k;
    logic [FN_W-1:0] f;
    bit ok;
    int e0;
    k = {$urandom, $urandom}; f = FN_W'($urandom);
    busy_stuck = 1'b1; init_cycles = 5; burst_ready = 1'b1; auto_next = 1'b0;
    e0 = ks_en_cnt;
    pulse_start(k, f);
    repeat (4 * TMO) tick();
    n_tests++;
    if (busy !== 1'b1 || err !== 1'b0 || ks_en_cnt != e0) begin
      n_fail++; $display("FAIL notmo_wait: busy=%b err=%b steps=%0d required 1 0 0", busy, err, ks_en_cnt - e0);
    end
    busy_stuck = 1'b0;
    wait_valid(800, ok);
    if (ok) begin
      n_tests++;
      if (burst_a !== exp_burst(k, f, 0) || burst_b !== exp_burst(k, f, 1) || err !== 1'b0) begin
        n_fail++; $display("FAIL notmo_frame: a=%h err=%b required %h 0", burst_a, err, exp_burst(k, f, 0));
      end
      tick();
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_known_vector();
    test_backpressure();
    test_auto_next_wrap();
    test_reset_mid_gen();
    test_start_ignored();
    test_back_to_back();
`ifdef A5_INIT_TMO_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
